// File: rtl/riscv_bp_table_ctrl_pkg.sv
// Shared types and helpers for the branch-predictor table controller.
// Holds the FSM state type, prediction encodings and the next-prediction rule.
package riscv_bp_table_ctrl_pkg;

    typedef enum logic {
        StIdle,
        StSweep
    } bp_state_e;

    // Saturating sequence: strong-NT <-> weak-NT <-> weak-T <-> strong-T
    localparam logic [1:0] PredStrongNt = 2'b00;
    localparam logic [1:0] PredWeakNt   = 2'b01;
    localparam logic [1:0] PredWeakT    = 2'b11;
    localparam logic [1:0] PredStrongT  = 2'b10;

    function automatic logic [1:0] bp_next_predict(input logic [1:0] pred, input logic taken);
        logic [1:0] nxt;
        nxt[0] = pred[1] ^ taken;
        nxt[1] = (pred[1] & ~pred[0]) | (taken & pred[0]);
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_bp_table_ctrl.sv
// Write-port controller for the branch history table: applies branch-unit updates
// and sweeps the whole table to INIT_PREDICT after reset or on a flush request.
module riscv_bp_table_ctrl
    import riscv_bp_table_ctrl_pkg::*;
#(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned BP_GLOBAL_BITS    = 2,
    parameter int unsigned BP_LOCAL_BITS     = 10,
    parameter int unsigned BP_LOCAL_BITS_LSB = 2,
    parameter logic [1:0]  INIT_PREDICT      = 2'b01
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_req_i,
    input  logic                                    bu_update_i,
    input  logic [XLEN-1:0]                         bu_pc_i,
    input  logic [BP_GLOBAL_BITS-1:0]               bu_history_i,
    input  logic [1:0]                              bu_predict_i,
    input  logic                                    bu_btaken_i,
    output logic                                    tbl_we_o,
    output logic [BP_GLOBAL_BITS+BP_LOCAL_BITS-1:0] tbl_waddr_o,
    output logic [1:0]                              tbl_wdata_o,
    output logic                                    busy_o,
    output logic                                    flush_done_o,
    output logic [7:0]                              drop_cnt_o
);

    localparam int unsigned ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;

    bp_state_e           state_q, state_d;
    logic [ADR_BITS-1:0] cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADR_BITS-1:0] waddr_q, waddr_d;
    logic [1:0]          wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          drop_q, drop_d;
    logic                drop;

    // Only a slice of the PC forms the table index.
    logic unused_pc;
    assign unused_pc = ^bu_pc_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = (state_q == StSweep);
        done_d  = 1'b0;
        drop    = 1'b0;

        // A flush always wins: restart from entry 0, discard any concurrent update.
        if (flush_req_i) begin
            state_d = StSweep;
            cnt_d   = '0;
            drop    = bu_update_i;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bu_update_i) begin
                        we_d    = 1'b1;
                        waddr_d = {bu_history_i, bu_pc_i[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]};
                        wdata_d = bp_next_predict(bu_predict_i, bu_btaken_i);
                    end
                end
                StSweep: begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = INIT_PREDICT;
                    cnt_d   = cnt_q + ADR_BITS'(1);
                    drop    = bu_update_i;
                    if (&cnt_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end

        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StSweep;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign tbl_we_o     = we_q;
    assign tbl_waddr_o  = waddr_q;
    assign tbl_wdata_o  = wdata_q;
    assign busy_o       = busy_q;
    assign flush_done_o = done_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_riscv_bp_table_ctrl.sv
// Directed and randomized checks of riscv_bp_table_ctrl against a sequence-based
// model of the 2-bit predictor and the expected sweep address stream.
module tb_riscv_bp_table_ctrl;

    localparam int XLEN  = 32;
    localparam int GB    = 2;
    localparam int LB    = 10;
    localparam int LSB   = 2;
    localparam int ADR   = GB + LB;
    localparam int DEPTH = 1 << ADR;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_req_i = 1'b0;
    logic            bu_update_i = 1'b0;
    logic [XLEN-1:0] bu_pc_i = '0;
    logic [GB-1:0]   bu_history_i = '0;
    logic [1:0]      bu_predict_i = '0;
    logic            bu_btaken_i = 1'b0;
    logic            tbl_we_o;
    logic [ADR-1:0]  tbl_waddr_o;
    logic [1:0]      tbl_wdata_o;
    logic            busy_o;
    logic            flush_done_o;
    logic [7:0]      drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_bp_table_ctrl #(
        .XLEN              (XLEN),
        .BP_GLOBAL_BITS    (GB),
        .BP_LOCAL_BITS     (LB),
        .BP_LOCAL_BITS_LSB (LSB),
        .INIT_PREDICT      (2'b01)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_req_i  (flush_req_i),
        .bu_update_i  (bu_update_i),
        .bu_pc_i      (bu_pc_i),
        .bu_history_i (bu_history_i),
        .bu_predict_i (bu_predict_i),
        .bu_btaken_i  (bu_btaken_i),
        .tbl_we_o     (tbl_we_o),
        .tbl_waddr_o  (tbl_waddr_o),
        .tbl_wdata_o  (tbl_wdata_o),
        .busy_o       (busy_o),
        .flush_done_o (flush_done_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Predictor walks the chain 00,01,11,10 one step per outcome, clamping at the ends.
    function automatic logic [1:0] model_next(input logic [1:0] p, input logic t);
        int idx;
        case (p)
            2'b00:   idx = 0;
            2'b01:   idx = 1;
            2'b11:   idx = 2;
            default: idx = 3;
        endcase
        idx = t ? ((idx == 3) ? 3 : idx + 1) : ((idx == 0) ? 0 : idx - 1);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // One sweep write at entry k: {we, busy, done, data, addr}.
    task automatic sweep_cycle(input int k, input string tag);
        tick();
        check(tag, 32'({tbl_we_o, busy_o, flush_done_o, tbl_wdata_o, tbl_waddr_o}),
              32'({1'b1, 1'b1, k == DEPTH - 1, 2'b01, ADR'(k)}));
    endtask

    task automatic full_sweep(input string tag);
        for (int k = 0; k < DEPTH; k++) sweep_cycle(k, tag);
        tick();
        check({tag, "_end"}, 32'({tbl_we_o, busy_o, flush_done_o}), 32'(3'b000));
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [1:0] h,
                                input logic [1:0] p, input logic t);
        bu_update_i  = 1'b1;
        bu_pc_i      = pc;
        bu_history_i = h;
        bu_predict_i = p;
        bu_btaken_i  = t;
    endtask

    initial begin
        logic [ADR-1:0] m_addr;
        logic [1:0]     m_data;
        logic [31:0]    pc;
        logic [1:0]     h, p;
        logic           t, upd;
        int             waited;

        // Reset values
        tick();
        tick();
        check("rst_busy", 32'(busy_o), 32'(1));
        check("rst_out", 32'({tbl_we_o, flush_done_o, tbl_wdata_o, tbl_waddr_o}), 32'(0));
        check("rst_drop", 32'(drop_cnt_o), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Automatic sweep after reset
        full_sweep("rst_sweep");

        // Directed updates
        drive_update(32'h0000_0104, 2'b10, 2'b01, 1'b1);
        tick();
        check("upd_a", 32'({tbl_we_o, tbl_waddr_o, tbl_wdata_o}), 32'({1'b1, 12'h841, 2'b11}));
        bu_update_i = 1'b0;
        tick();
        check("hold_a", 32'({tbl_we_o, tbl_waddr_o, tbl_wdata_o}), 32'({1'b0, 12'h841, 2'b11}));
        drive_update(32'h0000_0104, 2'b10, 2'b10, 1'b1);
        tick();
        check("upd_b", 32'(tbl_wdata_o), 32'(2'b10));
        drive_update(32'h0000_0104, 2'b10, 2'b10, 1'b0);
        tick();
        check("upd_c", 32'(tbl_wdata_o), 32'(2'b11));
        bu_update_i = 1'b0;
        tick();
        m_addr = 12'h841;
        m_data = 2'b11;

        // Randomized updates in IDLE
        for (int i = 0; i < 200; i++) begin
            upd = 1'($urandom_range(0, 1));
            pc  = $urandom;
            h   = 2'($urandom);
            p   = 2'($urandom);
            t   = 1'($urandom);
            drive_update(pc, h, p, t);
            bu_update_i = upd;
            tick();
            if (upd) begin
                m_addr = {h, pc[LSB +: LB]};
                m_data = model_next(p, t);
            end
            check("rand_upd", 32'({tbl_we_o, busy_o, tbl_waddr_o, tbl_wdata_o}),
                  32'({upd, 1'b0, m_addr, m_data}));
        end
        check("rand_drop", 32'(drop_cnt_o), 32'(0));

        // Flush and update together in IDLE: update dropped, sweep begins
        flush_req_i = 1'b1;
        bu_update_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        bu_update_i = 1'b0;
        check("flush_idle_we", 32'(tbl_we_o), 32'(0));
        check("flush_idle_drop", 32'(drop_cnt_o), 32'(1));
        for (int k = 0; k <= 100; k++) sweep_cycle(k, "pre_abort");

        // Flush at sweep address 100 restarts from 0 with a single completion
        flush_req_i = 1'b1;
        waited = 0;
        tick();
        flush_req_i = 1'b0;
        while (!tbl_we_o && waited < 4) begin
            waited++;
            tick();
        end
        check("restart_addr", 32'({tbl_we_o, tbl_waddr_o}), 32'({1'b1, 12'd0}));
        waited = flush_done_o ? 1 : 0;
        for (int k = 1; k < DEPTH; k++) begin
            sweep_cycle(k, "restart_sweep");
            if (flush_done_o) waited++;
        end
        check("restart_one_done", 32'(waited), 32'(1));
        tick();
        check("restart_idle", 32'({tbl_we_o, busy_o}), 32'(0));

        // Updates during a sweep are dropped and counted up to saturation
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            drive_update($urandom, 2'($urandom), 2'($urandom), 1'($urandom));
            bu_update_i = (k < 300);
            sweep_cycle(k, "drop_sweep");
            if (k == 310) check("drop_sat", 32'(drop_cnt_o), 32'(255));
        end
        bu_update_i = 1'b0;

        // Flush in the last sweep cycle suppresses completion
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        check("last_flush", 32'({tbl_we_o, flush_done_o, busy_o}), 32'(3'b001));
        full_sweep("after_last_flush");
        check("drop_kept", 32'(drop_cnt_o), 32'(255));

        // Reset asserted mid-sweep aborts at once
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        for (int k = 0; k < 20; k++) sweep_cycle(k, "pre_reset");
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst", 32'({tbl_we_o, busy_o, flush_done_o, tbl_wdata_o, tbl_waddr_o, drop_cnt_o}),
              32'({1'b0, 1'b1, 1'b0, 2'b00, 12'd0, 8'd0}));
        @(negedge clk_i);
        rst_i = 1'b0;
        sweep_cycle(0, "post_rst_first");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_bp_table_ctrl.md
RISCV_BP_TABLE_CTRL -- requirements
Module: riscv_bp_table_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- XLEN, 32, PC width.
- BP_GLOBAL_BITS, 2, global history bits in the table address.
- BP_LOCAL_BITS, 10, PC bits in the table address.
- BP_LOCAL_BITS_LSB, 2, lowest PC bit used in the address.
- INIT_PREDICT, 2'b01, value written to every entry by a sweep.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- flush_req_i, in, 1, single-cycle request to reinitialise the table.
- bu_update_i, in, 1, branch unit table update strobe.
- bu_pc_i, in, XLEN, PC of the resolved branch.
- bu_history_i, in, BP_GLOBAL_BITS, history used at prediction time.
- bu_predict_i, in, 2, old prediction bits.
- bu_btaken_i, in, 1, branch taken.
- tbl_we_o, out, 1, table write enable.
- tbl_waddr_o, out, BP_GLOBAL_BITS+BP_LOCAL_BITS, table write address.
- tbl_wdata_o, out, 2, table write data.
- busy_o, out, 1, sweep in progress; predictions are invalid.
- flush_done_o, out, 1, one-cycle pulse when a sweep completes.
- drop_cnt_o, out, 8, saturating count of updates dropped during sweeps.

Function
REQ-004 The FSM SHALL have two states, IDLE and SWEEP, plus an ADR_BITS-wide sweep counter, where ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS and DEPTH = 2^ADR_BITS.
REQ-005 All tbl_* outputs SHALL be registered, giving exactly one cycle from input to table write.
REQ-006 In SWEEP, every cycle SHALL drive tbl_we_o=1, tbl_waddr_o=counter and tbl_wdata_o=INIT_PREDICT, then increment the counter.
REQ-007 When the counter equals DEPTH-1, that cycle SHALL still write, then the FSM SHALL go to IDLE, the counter SHALL wrap to 0, and flush_done_o SHALL pulse in the cycle the last write is presented.
REQ-008 In IDLE with bu_update_i=1, the next cycle SHALL drive:
- tbl_we_o=1.
- tbl_waddr_o = {bu_history_i, bu_pc_i[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]}.
- tbl_wdata_o[0] = bu_predict_i[1] ^ bu_btaken_i.
- tbl_wdata_o[1] = (bu_predict_i[1] & ~bu_predict_i[0]) | (bu_btaken_i & bu_predict_i[0]).
- This is the 2-bit saturating sequence 00<->01<->11<->10.
REQ-009 In IDLE with bu_update_i=0, tbl_we_o SHALL be 0 the next cycle; tbl_waddr_o and tbl_wdata_o hold their values.
REQ-010 flush_req_i in IDLE SHALL enter SWEEP with counter 0; the first sweep write appears on the following cycle.
REQ-011 If flush_req_i and bu_update_i are both high in IDLE, the update SHALL be discarded and counted as dropped.
REQ-012 flush_req_i during SWEEP SHALL restart the sweep: the counter resets to 0 and no flush_done_o pulse is generated for the aborted sweep.
REQ-013 flush_req_i in the final sweep cycle SHALL restart the sweep and suppress flush_done_o.
REQ-014 Any bu_update_i during SWEEP SHALL be dropped with no table write.
REQ-015 Each dropped update SHALL increment drop_cnt_o, saturating at 255.
REQ-016 busy_o SHALL equal (state==SWEEP), registered and aligned with tbl_we_o of the sweep writes.

Reset
REQ-017 Reset SHALL force state=SWEEP, counter=0, busy_o=1, tbl_we_o=0, tbl_waddr_o=0, tbl_wdata_o=0, flush_done_o=0 and drop_cnt_o=0.
REQ-018 Reset SHALL therefore start an automatic full sweep; the first write appears on the first clock after reset deassertion.
REQ-019 Reset asserted mid-sweep or mid-update SHALL abort immediately, with no partial write after assertion.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the 2-bit prediction encoding constants, and the next-prediction function.
REQ-021 No sub-module SHALL be instantiated; the table RAM stays outside and is fed directly by tbl_* outputs.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset release -> 4096 consecutive writes to addresses 0..4095 with data 2'b01; flush_done_o pulses with address 4095; busy_o then drops to 0.
- IDLE, update with bu_pc_i=0x0000_0104, bu_history_i=2'b10, bu_predict_i=2'b01, bu_btaken_i=1 -> next cycle write to address 0x841 with data 2'b11.
- IDLE, update with bu_predict_i=2'b10, bu_btaken_i=1 -> data 2'b10; with bu_btaken_i=0 -> data 2'b11.
- flush_req_i at sweep address 100 -> next write goes to address 0; exactly one flush_done_o after 4096 further writes.
- 300 updates during a sweep -> no update writes; drop_cnt_o reads 255.
- flush_req_i and bu_update_i in the same IDLE cycle -> no update write; sweep starts; drop_cnt_o increments by 1.
